// File: rtl/imem_stream_loaded.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// imem_stream_loaded
//   Synchronous instruction memory that is filled by a streaming load port
//   after reset and then serves the IF stage via a registered fetch port with
//   stall support and range/alignment checking.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   load_valid_i   load_data_i is valid this cycle (LOAD state only)
//   load_data_i    program word stored at the load pointer
//   load_last_i    marks the final program word; moves the FSM to RUN
//   reload_i       return to LOAD with the pointer restarted at 0
//   fetch_req_i    fetch request for fetch_addr_i (RUN state only)
//   fetch_addr_i   word index or byte address, depending on BYTE_ADDR
//   fetch_stall_i  hold fetch outputs and drop fetch_req_i
//   fetch_instr_o  registered instruction (NOP_WORD on invalid fetch)
//   fetch_valid_o  fetch_instr_o carries the result of an accepted fetch
//   fetch_err_o    the accepted fetch was out of range or misaligned
//   ready_o        program loaded, fetches are served
//   prog_len_o     number of words loaded, saturating at DEPTH
//   load_ovf_o     sticky flag: a word arrived with the memory already full
// ----------------------------------------------------------------------------
module imem_stream_loaded #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 32,
  parameter int BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h68000000)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid_i,
  input  logic [DATA_W-1:0]        load_data_i,
  input  logic                     load_last_i,
  input  logic                     reload_i,
  input  logic                     fetch_req_i,
  input  logic [ADDR_W-1:0]        fetch_addr_i,
  input  logic                     fetch_stall_i,
  output logic [DATA_W-1:0]        fetch_instr_o,
  output logic                     fetch_valid_o,
  output logic                     fetch_err_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   prog_len_o,
  output logic                     load_ovf_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  // Range check is done at the wider of address and length so that upper
  // address bits can never wrap into a valid index.
  localparam int CMP_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t              state_q;
  logic [LEN_W-1:0]    load_ptr_q;
  logic                load_ovf_q;
  logic [DATA_W-1:0]   instr_q;
  logic                valid_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   fetch_idx;
  logic                misaligned;
  logic                fetch_bad;
  logic                load_room;
  logic                load_we;
  logic [DATA_W-1:0]   rd_word;

  // Fetch decode and load-side write enable. The load pointer doubles as the
  // program length, so the range check compares against it directly.
  always_comb begin
    fetch_idx  = (BYTE_ADDR != 0) ? (fetch_addr_i >> 2) : fetch_addr_i;
    misaligned = (BYTE_ADDR != 0) && (fetch_addr_i[1:0] != 2'b00);
    fetch_bad  = (CMP_W'(fetch_idx) >= CMP_W'(load_ptr_q)) || misaligned;
    rd_word    = mem_q[fetch_idx[IDX_W-1:0]];
    load_room  = (load_ptr_q < LEN_W'(DEPTH));
    load_we    = (state_q == S_LOAD) && load_valid_i && load_room && !reload_i;
  end

  // Program storage; deliberately not reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[load_ptr_q[IDX_W-1:0]] <= load_data_i;
    end
  end

  // Control FSM with registered fetch outputs. reload has top priority in
  // both states and returns every output to its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      load_ptr_q <= '0;
      load_ovf_q <= 1'b0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (reload_i) begin
      state_q    <= S_LOAD;
      load_ptr_q <= '0;
      load_ovf_q <= 1'b0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          if (load_valid_i) begin
            if (load_room) begin
              load_ptr_q <= load_ptr_q + LEN_W'(1);
            end else begin
              load_ovf_q <= 1'b1;
            end
            // An overflowing last word is still dropped but ends the load.
            if (load_last_i) begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // A stalled cycle holds all outputs and drops the request.
          if (!fetch_stall_i) begin
            if (fetch_req_i) begin
              valid_q <= 1'b1;
              err_q   <= fetch_bad;
              instr_q <= fetch_bad ? NOP_WORD : rd_word;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign fetch_instr_o = instr_q;
  assign fetch_valid_o = valid_q;
  assign fetch_err_o   = err_q;
  assign ready_o       = (state_q == S_RUN);
  assign prog_len_o    = load_ptr_q;
  assign load_ovf_o    = load_ovf_q;

endmodule
